intc_irq_cap: RTL

INTC_IRQ_CAP -- requirements
Module: intc_irq_cap

---
 rtl/intc_pkg.sv | 21 ++
 rtl/intc_filt.sv | 51 +++++
 rtl/intc_irq_cap.sv | 116 +++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | intc_pkg: shared detect-mode encoding and default sizes for the   |
// | interrupt capture block.   Revision: 1.0                          |
// +------------------------------------------------------------------+
package intc_pkg;

    typedef enum logic [1:0] {
        INTC_LVL  = 2'b00,
        INTC_RISE = 2'b01,
        INTC_FALL = 2'b10,
        INTC_BOTH = 2'b11
    } intc_mode_e;

    localparam int c_INT_NUM_DEF    = 64;
    localparam int c_SW_INT_NUM_DEF = 16;
    localparam int c_SYNC_STG_DEF   = 2;
    localparam int c_FILT_W_DEF     = 4;

endpackage
`default_nettype wire

// File: rtl/intc_filt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | intc_filt: one hardware channel -- synchroniser chain followed by |
// | a persistence glitch filter.   Revision: 1.0                      |
// +------------------------------------------------------------------+
module intc_filt
    import intc_pkg::*;
#(
    parameter int SYNC_STG = c_SYNC_STG_DEF,
    parameter int FILT_W   = c_FILT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_i,
    input  logic [FILT_W-1:0] filt_i,
    output logic              lvl_o
);

    logic [SYNC_STG-1:0] r_sync;
    logic [FILT_W-1:0]   r_cnt;
    logic                r_lvl;
    logic                w_synced;

    assign w_synced = r_sync[SYNC_STG-1];
    assign lvl_o    = r_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], din_i};
        end
    end

    // The level only moves once the new value has persisted filt_i+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
        end else if (w_synced == r_lvl) begin
            r_cnt <= '0;
        end else if (r_cnt == filt_i) begin
            r_lvl <= w_synced;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + FILT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/intc_irq_cap.sv
`default_nettype none
// +------------------------------------------------------------------+
// | intc_irq_cap: per-channel interrupt capture -- level/edge detect  |
// | and pending state for software and hardware sources. Rev: 1.0     |
// +------------------------------------------------------------------+
module intc_irq_cap
    import intc_pkg::*;
#(
    parameter int INT_NUM    = c_INT_NUM_DEF,
    parameter int SW_INT_NUM = c_SW_INT_NUM_DEF,
    parameter int SYNC_STG   = c_SYNC_STG_DEF,
    parameter int FILT_W     = c_FILT_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [INT_NUM-SW_INT_NUM-1:0]    intreq_i,
    input  logic [SW_INT_NUM-1:0]            rg_sint_i,
    input  logic [INT_NUM-1:0]               rg_ie_i,
    input  logic [INT_NUM-1:0]               rg_irqc_i,
    input  logic [INT_NUM-1:0][1:0]          rg_mode_i,
    input  logic [FILT_W-1:0]                rg_filt_i,
    input  logic [INT_NUM-1:0]               cp_intack_i,
    output logic [INT_NUM-1:0]               in_intreq_o,
    output logic [INT_NUM-1:0]               in_irq_o,
    output logic [INT_NUM-1:0]               in_lvl_o
);

    localparam int c_HW_NUM = INT_NUM - SW_INT_NUM;

    logic [c_HW_NUM-1:0]      w_hw_lvl;
    logic [SW_INT_NUM-1:0]    r_sw_lvl;
    logic [INT_NUM-1:0]       w_lvl;
    logic [INT_NUM-1:0]       r_prev;
    logic [INT_NUM-1:0][1:0]  r_mode;
    logic [INT_NUM-1:0]       r_pend;
    logic [INT_NUM-1:0]       w_rise;
    logic [INT_NUM-1:0]       w_fall;
    logic [INT_NUM-1:0]       w_clr;
    logic [INT_NUM-1:0]       w_evt;
    logic [INT_NUM-1:0]       w_pend_nxt;

    genvar g;
    generate
        for (g = 0; g < c_HW_NUM; g++) begin : g_hw
            intc_filt #(
                .SYNC_STG (SYNC_STG),
                .FILT_W   (FILT_W)
            ) u_filt (
                .clk    (clk),
                .rst_n  (rst_n),
                .din_i  (intreq_i[g]),
                .filt_i (rg_filt_i),
                .lvl_o  (w_hw_lvl[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_lvl <= '0;
        end else begin
            r_sw_lvl <= rg_sint_i;
        end
    end

    assign w_lvl  = {w_hw_lvl, r_sw_lvl};
    assign w_rise = w_lvl & ~r_prev;
    assign w_fall = ~w_lvl & r_prev;
    assign w_clr  = rg_irqc_i | cp_intack_i;

    always_comb begin
        w_evt = '0;
        for (int i = 0; i < INT_NUM; i++) begin
            unique case (intc_mode_e'(rg_mode_i[i]))
                INTC_RISE: w_evt[i] = w_rise[i];
                INTC_FALL: w_evt[i] = w_fall[i];
                INTC_BOTH: w_evt[i] = w_rise[i] | w_fall[i];
                default:   w_evt[i] = 1'b0;
            endcase
        end
    end

    // A mode rewrite wins over everything so a stale edge cannot leak across modes.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < INT_NUM; i++) begin
            if (rg_mode_i[i] != r_mode[i]) begin
                w_pend_nxt[i] = 1'b0;
            end else if (intc_mode_e'(rg_mode_i[i]) == INTC_LVL) begin
                w_pend_nxt[i] = w_lvl[i];
            end else if (w_evt[i]) begin
                w_pend_nxt[i] = 1'b1;
            end else if (w_clr[i]) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_mode <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= w_lvl;
            r_mode <= rg_mode_i;
            r_pend <= w_pend_nxt;
        end
    end

    assign in_irq_o    = r_pend;
    assign in_intreq_o = r_pend & rg_ie_i;
    assign in_lvl_o    = w_lvl;

endmodule
`default_nettype wire
